oddeven_sort_array: RTL and testbench
=====================================

Name: oddeven_sort_array

Overview:
- Datapath responder for the odd-even transposition sort controller.
- Accepts N unsigned words over a valid/ready load stream.
- Requests a sort from the controller with sort_en, then applies one compare-swap phase per even_cmp_en/odd_cmp_en pulse.
- On sort_finish, streams the sorted words out in ascending order over a valid/ready unload stream with a last marker.

Parameters:
- DATA_W, 8, width of each element in bits.
- N, 8, number of elements. Must be even and at least 2.
- CNT_W, $clog2(N), width of the load and unload index counters.

Ports:
- clk, input, 1, single clock domain; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset: 0 resets all state immediately, deassertion is synchronous to clk.
- in_valid, input, 1, load word present.
- in_data, input, DATA_W, load word.
- in_ready, output, 1, array accepts a load word this cycle.
- sort_en, output, 1, sort request to the controller.
- sort_finish, input, 1, controller reports that all phases have been issued.
- even_cmp_en, input, 1, apply an even phase this cycle.
- odd_cmp_en, input, 1, apply an odd phase this cycle.
- out_valid, output, 1, unload word present.
- out_data, output, DATA_W, unload word.
- out_last, output, 1, marks the final (N-1th) unload word.
- out_ready, input, 1, downstream accepts the unload word.
- busy, output, 1, high in SORT and UNLOAD.

Behaviour:
- Reset values:
  - FSM = LOAD.
  - Element registers e[0..N-1] = 0.
  - Load index and unload index = 0.
  - in_ready = 1, sort_en = 0, out_valid = 0, out_last = 0, out_data = 0, busy = 0.
- FSM states: LOAD, SORT, UNLOAD.
- LOAD:
  - in_ready = 1.
  - On in_valid & in_ready: e[lidx] <= in_data and lidx increments.
  - The handshake with lidx == N-1 loads the word, clears lidx, and moves to SORT on the next cycle.
  - Compare enables and sort_finish are ignored in this state.
- SORT:
  - in_ready = 0, sort_en = 1 (registered, high from the first SORT cycle), busy = 1.
  - Even phase (even_cmp_en = 1): for every i = 0, 2, ..., N-2, if e[i] > e[i+1] then swap them. All pairs update in the same cycle.
  - Odd phase (odd_cmp_en = 1, even_cmp_en = 0): for every i = 1, 3, ..., N-3, if e[i] > e[i+1] then swap them. e[0] and e[N-1] are unchanged.
  - Comparison is unsigned. Equal values are not swapped.
  - Each phase takes one cycle; its result is visible in e[] the next cycle.
  - Both enables high in the same cycle: the even phase is applied and the odd enable is dropped.
  - sort_finish = 1: any phase enable in that same cycle is still applied. Next cycle, sort_en = 0 and the state is UNLOAD.
- UNLOAD:
  - out_valid = 1, out_data = e[uidx], out_last = (uidx == N-1). Outputs are combinational from the registers and stable while out_ready = 0.
  - On out_valid & out_ready: uidx increments.
  - The handshake with out_last = 1 clears uidx and returns to LOAD, so in_ready = 1 on the next cycle.
  - Phase enables are ignored in this state.
- Throughput: N load cycles + controller phases + 1 transition cycle + N unload cycles, with no bubbles when in_valid and out_ready are held high.
- Reset asserted mid-operation (any state) aborts the operation: all registers return to their reset values and the partially sorted data is discarded.
- sort_finish arriving in LOAD or UNLOAD is ignored.

Test Plan:
- Basic sort: load 5,3,7,1,8,2,6,4, then issue 8 alternating phases starting with even, then sort_finish. Required response: sort_en is high from the cycle after the 8th load until the cycle after sort_finish, and the unload stream is 1,2,3,4,5,6,7,8 with out_last only on 8.
- Reverse input with duplicates: load 9,9,7,7,5,5,3,3 with 8 phases. Required response: 3,3,5,5,7,7,9,9; no swap occurs on equal pairs (check e[] after each phase).
- Simultaneous enables: after loading 2,1,4,3,6,5,8,7, assert even_cmp_en and odd_cmp_en together for one cycle. Required response: e[] = 1,2,3,4,5,6,7,8, i.e. only the even phase is applied.
- Ignored events: pulse even_cmp_en, odd_cmp_en and sort_finish during LOAD, and phase enables during UNLOAD. Required response: loaded values and the output order are unchanged.
- Backpressure: toggle out_ready 1,0,0,1,... during unload. Required response: out_data and out_last are held while out_ready is 0, exactly 8 words are transferred in order, and in_ready returns one cycle after the last handshake.
- Reset mid-sort: drop rst to 0 after 3 phases. Required response: immediately sort_en = 0, out_valid = 0, in_ready = 1, and e[] all 0. After release, a fresh load/sort of 4,3,2,1,8,7,6,5 outputs 1..8.

Source files
------------

// File: rtl/oddeven_sort_array.sv
// -----------------------------------------------------------------------------
// oddeven_sort_array
//
// Datapath responder for an odd-even transposition sort controller. Words are
// loaded over a valid/ready stream into an N-entry register array. The block
// then raises sort_en, applies one compare-swap phase per even/odd enable
// pulse, and streams the array out in ascending order after sort_finish.
//
// Ports:
//   clk          - single clock, rising edge
//   rst          - asynchronous active-low reset
//   in_valid     - load word present
//   in_data      - load word
//   in_ready     - array accepts a load word (high in LOAD)
//   sort_en      - sort request to the controller (high in SORT)
//   sort_finish  - controller has issued all phases
//   even_cmp_en  - apply even phase (pairs 0-1, 2-3, ...)
//   odd_cmp_en   - apply odd phase (pairs 1-2, 3-4, ...)
//   out_valid    - unload word present (high in UNLOAD)
//   out_data     - unload word, e[uidx]
//   out_last     - final unload word marker
//   out_ready    - downstream accepts the unload word
//   busy         - high in SORT and UNLOAD
// -----------------------------------------------------------------------------
module oddeven_sort_array #(
   parameter int DATA_W = 8,
   parameter int N      = 8,
   parameter int CNT_W  = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              sort_en,
   input  logic              sort_finish,
   input  logic              even_cmp_en,
   input  logic              odd_cmp_en,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SORT   = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
   localparam logic [CNT_W-1:0] ONE_IDX  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO_IDX = {CNT_W{1'b0}};

   state_t            state_r;
   state_t            state_nxt_s;
   logic [CNT_W-1:0]  lidx_r;
   logic [CNT_W-1:0]  lidx_nxt_s;
   logic [CNT_W-1:0]  uidx_r;
   logic [CNT_W-1:0]  uidx_nxt_s;
   logic [DATA_W-1:0] e_r     [N];
   logic [DATA_W-1:0] e_nxt_s [N];

   // Next-state, index and element-array update logic.
   always_comb begin
      state_nxt_s = state_r;
      lidx_nxt_s  = lidx_r;
      uidx_nxt_s  = uidx_r;
      for (int i = 0; i < N; i++) begin
         e_nxt_s[i] = e_r[i];
      end

      case (state_r)
         ST_LOAD: begin
            // in_ready is high for the whole state, so in_valid is the handshake.
            if (in_valid) begin
               e_nxt_s[lidx_r] = in_data;
               if (lidx_r == LAST_IDX) begin
                  lidx_nxt_s  = ZERO_IDX;
                  state_nxt_s = ST_SORT;
               end else begin
                  lidx_nxt_s  = lidx_r + ONE_IDX;
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               lidx_nxt_s  = lidx_r;
               state_nxt_s = ST_LOAD;
            end
         end

         ST_SORT: begin
            // Even takes priority when both enables arrive together.
            if (even_cmp_en) begin
               for (int p = 0; p < N / 2; p++) begin
                  if (e_r[2*p] > e_r[2*p+1]) begin
                     e_nxt_s[2*p]   = e_r[2*p+1];
                     e_nxt_s[2*p+1] = e_r[2*p];
                  end else begin
                     e_nxt_s[2*p]   = e_r[2*p];
                     e_nxt_s[2*p+1] = e_r[2*p+1];
                  end
               end
            end else if (odd_cmp_en) begin
               // End elements have no odd partner and keep their values.
               for (int p = 0; p < N / 2 - 1; p++) begin
                  if (e_r[2*p+1] > e_r[2*p+2]) begin
                     e_nxt_s[2*p+1] = e_r[2*p+2];
                     e_nxt_s[2*p+2] = e_r[2*p+1];
                  end else begin
                     e_nxt_s[2*p+1] = e_r[2*p+1];
                     e_nxt_s[2*p+2] = e_r[2*p+2];
                  end
               end
            end else begin
               for (int i = 0; i < N; i++) begin
                  e_nxt_s[i] = e_r[i];
               end
            end

            if (sort_finish) begin
               state_nxt_s = ST_UNLOAD;
            end else begin
               state_nxt_s = ST_SORT;
            end
         end

         ST_UNLOAD: begin
            // out_valid is high for the whole state, so out_ready is the handshake.
            if (out_ready) begin
               if (uidx_r == LAST_IDX) begin
                  uidx_nxt_s  = ZERO_IDX;
                  state_nxt_s = ST_LOAD;
               end else begin
                  uidx_nxt_s  = uidx_r + ONE_IDX;
                  state_nxt_s = ST_UNLOAD;
               end
            end else begin
               uidx_nxt_s  = uidx_r;
               state_nxt_s = ST_UNLOAD;
            end
         end

         default: begin
            state_nxt_s = ST_LOAD;
            lidx_nxt_s  = ZERO_IDX;
            uidx_nxt_s  = ZERO_IDX;
         end
      endcase
   end

   // State, index and element registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_LOAD;
         lidx_r  <= ZERO_IDX;
         uidx_r  <= ZERO_IDX;
         for (int i = 0; i < N; i++) begin
            e_r[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_r <= state_nxt_s;
         lidx_r  <= lidx_nxt_s;
         uidx_r  <= uidx_nxt_s;
         for (int i = 0; i < N; i++) begin
            e_r[i] <= e_nxt_s[i];
         end
      end
   end

   // Status outputs decode directly from the state register.
   assign in_ready  = (state_r == ST_LOAD);
   assign sort_en   = (state_r == ST_SORT);
   assign out_valid = (state_r == ST_UNLOAD);
   assign busy      = (state_r != ST_LOAD);
   assign out_last  = (state_r == ST_UNLOAD) && (uidx_r == LAST_IDX);
   assign out_data  = (state_r == ST_UNLOAD) ? e_r[uidx_r] : {DATA_W{1'b0}};

endmodule

// File: tb/tb_oddeven_sort_array.sv
// -----------------------------------------------------------------------------
// tb_oddeven_sort_array
//
// Self-checking bench for oddeven_sort_array. Expected unload words are pushed
// to a scoreboard queue when a vector is loaded and popped on each unload
// handshake. A small reference model of the element array tracks each phase.
// -----------------------------------------------------------------------------
module tb_oddeven_sort_array;

   localparam int DATA_W = 8;
   localparam int N      = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              sort_en;
   logic              sort_finish;
   logic              even_cmp_en;
   logic              odd_cmp_en;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic              busy;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } exp_t;

   exp_t              sb_q [$];
   logic [DATA_W-1:0] vec [N];
   logic [DATA_W-1:0] mdl [N];
   int                n_cmp = 0;
   int                n_bad = 0;

   oddeven_sort_array #(.DATA_W(DATA_W), .N(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .sort_en(sort_en), .sort_finish(sort_finish),
      .even_cmp_en(even_cmp_en), .odd_cmp_en(odd_cmp_en),
      .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
      .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_array();
      for (int i = 0; i < N; i++) begin
         check_val($sformatf("e%0d", i), 32'(dut.e_r[i]), 32'(mdl[i]));
      end
   endtask

   // Load vec[], optionally pulsing enables/finish that LOAD must ignore.
   task automatic load_vec(input bit ign);
      logic [DATA_W-1:0] s [N];
      logic [DATA_W-1:0] t;
      exp_t              x;
      for (int i = 0; i < N; i++) begin
         check_val("load_in_ready", 32'(in_ready), 32'd1);
         check_val("load_sort_en", 32'(sort_en), 32'd0);
         in_valid = 1'b1;
         in_data  = vec[i];
         if (ign) begin
            even_cmp_en = (i % 2 == 0);
            odd_cmp_en  = (i % 2 == 1);
            sort_finish = (i == 3) || (i == N - 1);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; even_cmp_en = 1'b0; odd_cmp_en = 1'b0; sort_finish = 1'b0;
      for (int i = 0; i < N; i++) begin
         mdl[i] = vec[i];
         s[i]   = vec[i];
      end
      check_array();
      check_val("sort_en_first", 32'(sort_en), 32'd1);
      check_val("sort_in_ready", 32'(in_ready), 32'd0);
      check_val("sort_busy", 32'(busy), 32'd1);
      for (int a = 0; a < N; a++) begin
         for (int b = 0; b < N - 1 - a; b++) begin
            if (s[b] > s[b+1]) begin
               t = s[b]; s[b] = s[b+1]; s[b+1] = t;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         x.data = s[i];
         x.last = (i == N - 1);
         sb_q.push_back(x);
      end
   endtask

   // One SORT cycle with the given enables; model follows and e[] is compared.
   task automatic phase(input bit ev, input bit od, input bit fin);
      logic [DATA_W-1:0] t;
      even_cmp_en = ev; odd_cmp_en = od; sort_finish = fin;
      @(posedge clk); #1;
      even_cmp_en = 1'b0; odd_cmp_en = 1'b0; sort_finish = 1'b0;
      if (ev) begin
         for (int p = 0; p < N; p += 2) begin
            if (mdl[p] > mdl[p+1]) begin
               t = mdl[p]; mdl[p] = mdl[p+1]; mdl[p+1] = t;
            end
         end
      end else if (od) begin
         for (int p = 1; p < N - 1; p += 2) begin
            if (mdl[p] > mdl[p+1]) begin
               t = mdl[p]; mdl[p] = mdl[p+1]; mdl[p+1] = t;
            end
         end
      end
      check_array();
      check_val("phase_sort_en", 32'(sort_en), fin ? 32'd0 : 32'd1);
      check_val("phase_out_valid", 32'(out_valid), fin ? 32'd1 : 32'd0);
   endtask

   // Drain the array; bp selects the 1,0,0 out_ready pattern.
   task automatic unload(input bit bp, input bit ign);
      int                got  = 0;
      int                k    = 0;
      bit                held = 1'b0;
      logic [DATA_W-1:0] pd;
      logic              pl;
      exp_t              x;
      while (got < N && k < 100) begin
         out_ready = bp ? (k % 3 == 0) : 1'b1;
         if (ign) begin
            even_cmp_en = 1'b1;
            odd_cmp_en  = (k % 2 == 1);
         end
         check_val("unl_valid", 32'(out_valid), 32'd1);
         if (held) begin
            check_val("hold_data", 32'(out_data), 32'(pd));
            check_val("hold_last", 32'(out_last), 32'(pl));
         end
         if (out_ready) begin
            if (sb_q.size() == 0) begin
               check_val("sb_empty", 32'd0, 32'd1);
            end else begin
               x = sb_q.pop_front();
               check_val("out_data", 32'(out_data), 32'(x.data));
               check_val("out_last", 32'(out_last), 32'(x.last));
            end
            got++;
            held = 1'b0;
         end else begin
            held = 1'b1;
            pd   = out_data;
            pl   = out_last;
         end
         @(posedge clk); #1;
         k++;
      end
      out_ready = 1'b0; even_cmp_en = 1'b0; odd_cmp_en = 1'b0;
      if (got < N) begin
         check_val("unload_timeout", 32'(got), 32'(N));
      end
      check_val("ret_in_ready", 32'(in_ready), 32'd1);
      check_val("ret_out_valid", 32'(out_valid), 32'd0);
      check_val("ret_busy", 32'(busy), 32'd0);
   endtask

   task automatic alt_phases(input int n, input bit fin_on_last);
      for (int p = 0; p < n; p++) begin
         phase(p % 2 == 0, p % 2 == 1, fin_on_last && (p == n - 1));
      end
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = '0; sort_finish = 1'b0;
      even_cmp_en = 1'b0; odd_cmp_en = 1'b0; out_ready = 1'b0;
      #12;
      check_val("rst_in_ready", 32'(in_ready), 32'd1);
      check_val("rst_sort_en", 32'(sort_en), 32'd0);
      check_val("rst_out_valid", 32'(out_valid), 32'd0);
      check_val("rst_out_last", 32'(out_last), 32'd0);
      check_val("rst_out_data", 32'(out_data), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      for (int i = 0; i < N; i++) mdl[i] = '0;
      check_array();
      rst = 1'b1;
      @(posedge clk); #1;

      // Basic sort, finish on its own cycle.
      vec = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
      load_vec(1'b0);
      alt_phases(8, 1'b0);
      phase(1'b0, 1'b0, 1'b1);
      unload(1'b0, 1'b0);

      // Duplicates, finish together with the last phase.
      vec = '{8'd9, 8'd9, 8'd7, 8'd7, 8'd5, 8'd5, 8'd3, 8'd3};
      load_vec(1'b0);
      alt_phases(8, 1'b1);
      unload(1'b0, 1'b0);

      // Simultaneous enables: even wins.
      vec = '{8'd2, 8'd1, 8'd4, 8'd3, 8'd6, 8'd5, 8'd8, 8'd7};
      load_vec(1'b0);
      phase(1'b1, 1'b1, 1'b0);
      phase(1'b0, 1'b0, 1'b1);
      unload(1'b0, 1'b0);

      // Ignored events in LOAD and UNLOAD, plus backpressure.
      vec = '{8'd200, 8'd0, 8'd255, 8'd17, 8'd17, 8'd128, 8'd1, 8'd99};
      load_vec(1'b1);
      alt_phases(8, 1'b1);
      unload(1'b1, 1'b1);

      // Reset mid-sort.
      vec = '{8'd5, 8'd3, 8'd7, 8'd1, 8'd8, 8'd2, 8'd6, 8'd4};
      load_vec(1'b0);
      alt_phases(3, 1'b0);
      rst = 1'b0;
      #1;
      check_val("mid_rst_sort_en", 32'(sort_en), 32'd0);
      check_val("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check_val("mid_rst_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < N; i++) mdl[i] = '0;
      check_array();
      sb_q.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      vec = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd8, 8'd7, 8'd6, 8'd5};
      load_vec(1'b0);
      alt_phases(8, 1'b1);
      unload(1'b0, 1'b0);

      check_val("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
